// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared types for the per-scanline sprite scheduler.
//   CORDW / SPR_H / N_SPR : default geometry. The structs below are sized from
//                           these values, so a design that overrides the matching
//                           module parameters must change this package as well.
//   sprite_t              : one sprite table entry {en, x, y}
//   slot_t                : one scheduled engine slot {x, row, id}
//   sched_state_e         : scheduler FSM states
// -----------------------------------------------------------------------------
package sprite_pkg;

   localparam int CORDW = 16;
   localparam int SPR_H = 8;
   localparam int N_SPR = 8;
   localparam int ROW_W = $clog2(SPR_H);
   localparam int ID_W  = $clog2(N_SPR);

   typedef struct packed {
      logic                    en;
      logic signed [CORDW-1:0] x;
      logic signed [CORDW-1:0] y;
   } sprite_t;

   typedef struct packed {
      logic signed [CORDW-1:0] x;
      logic [ROW_W-1:0]        row;
      logic [ID_W-1:0]         id;
   } slot_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_ISSUE = 2'd2
   } sched_state_e;

endpackage

// File: rtl/sprite_hit_check.sv
// -----------------------------------------------------------------------------
// sprite_hit_check
// Combinational test of one sprite against the current scanline.
//   spr    in  sprite_t  table entry under test
//   line_y in  CORDW     signed scanline index
//   idx    in  ID_W      table index of the entry (passed into the slot record)
//   hit    out 1         sprite enabled and covers line_y
//   slot   out slot_t    {x, row = line_y - y, id = idx} for a hit
// -----------------------------------------------------------------------------
module sprite_hit_check
   import sprite_pkg::*;
(
   input  sprite_t                 spr,
   input  logic signed [CORDW-1:0] line_y,
   input  logic [ID_W-1:0]         idx,
   output logic                    hit,
   output slot_t                   slot
);

   // One extra bit so that line_y - y never wraps at the coordinate extremes.
   logic signed [CORDW:0] diff;

   always_comb begin
      diff      = $signed({line_y[CORDW-1], line_y}) - $signed({spr.y[CORDW-1], spr.y});
      hit       = spr.en && !diff[CORDW] && (diff < (CORDW+1)'(SPR_H));
      slot.x    = spr.x;
      slot.row  = diff[ROW_W-1:0];
      slot.id   = idx;
   end

endmodule

// File: rtl/sprite_line_scheduler.sv
// -----------------------------------------------------------------------------
// sprite_line_scheduler
// Per-scanline sprite scheduler. A shadow sprite table is written at any time
// and copied to the active table on each frame pulse. On each line pulse the
// active table is scanned one sprite per cycle; the first N_SLOT hits (lowest
// index first) are collected and then issued to the engine slots together with
// a one-cycle start pulse per filled slot.
//   i_clk_25      in   pixel clock
//   i_rst_n       in   asynchronous active-low reset
//   i_line        in   start of h-blank before line i_sy (1-cycle pulse)
//   i_frame       in   start of frame (1-cycle pulse): table copy, overflow clear
//   i_sy          in   signed line index, valid with i_line
//   i_cfg_we/idx/en/x/y   shadow table write port
//   o_slot_start  out  per-slot start pulse
//   o_slot_vld    out  per-slot "holds a sprite for this line"
//   o_slot_x/row/id out per-slot sprite x, row within sprite, sprite index
//   o_busy        out  scan or issue in progress
//   o_overflow    out  sticky: more than N_SLOT hits on a line this frame
// -----------------------------------------------------------------------------
module sprite_line_scheduler #(
   parameter int N_SPR  = 8,
   parameter int N_SLOT = 4,
   parameter int CORDW  = 16,
   parameter int SPR_H  = 8
) (
   input  logic                                i_clk_25,
   input  logic                                i_rst_n,
   input  logic                                i_line,
   input  logic                                i_frame,
   input  logic signed [CORDW-1:0]             i_sy,
   input  logic                                i_cfg_we,
   input  logic [$clog2(N_SPR)-1:0]            i_cfg_idx,
   input  logic                                i_cfg_en,
   input  logic signed [CORDW-1:0]             i_cfg_x,
   input  logic signed [CORDW-1:0]             i_cfg_y,
   output logic [N_SLOT-1:0]                   o_slot_start,
   output logic [N_SLOT-1:0]                   o_slot_vld,
   output logic [N_SLOT*CORDW-1:0]             o_slot_x,
   output logic [N_SLOT*$clog2(SPR_H)-1:0]     o_slot_row,
   output logic [N_SLOT*$clog2(N_SPR)-1:0]     o_slot_id,
   output logic                                o_busy,
   output logic                                o_overflow
);

   import sprite_pkg::*;

   localparam int IW = $clog2(N_SPR);
   localparam int RW = $clog2(SPR_H);
   localparam int CW = $clog2(N_SLOT+1);

   sched_state_e             state_q, state_d;

   sprite_t                  shadow_q [N_SPR];
   sprite_t                  shadow_d [N_SPR];
   sprite_t                  active_q [N_SPR];

   logic [IW-1:0]            idx_q;
   logic signed [CORDW-1:0]  line_y_q;
   logic [CW-1:0]            cnt_q, cnt_d;
   slot_t                    pend_q [N_SLOT];
   slot_t                    pend_d [N_SLOT];
   slot_t                    out_q  [N_SLOT];
   logic [N_SLOT-1:0]        mask_d;
   logic [N_SLOT-1:0]        vld_q, start_q;
   logic                     ovf_q;

   logic                     hit;
   slot_t                    hit_slot;
   logic                     scan_last;
   logic                     take, spill, load_out;

   // ---------------------------------------------------------------- table
   // The write is merged before the frame copy so that a write landing in the
   // frame-pulse cycle still reaches the active table in that same cycle.
   always_comb begin
      for (int i = 0; i < N_SPR; i++) begin
         shadow_d[i] = shadow_q[i];
         if (i_cfg_we && (i_cfg_idx == IW'(i)))
            shadow_d[i] = {i_cfg_en, i_cfg_x, i_cfg_y};
      end
   end

   always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < N_SPR; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_SPR; i++) begin
            shadow_q[i] <= shadow_d[i];
            if (i_frame)
               active_q[i] <= shadow_d[i];
         end
      end
   end

   // ---------------------------------------------------------------- hit test
   sprite_hit_check u_hit (
      .spr    (active_q[idx_q]),
      .line_y (line_y_q),
      .idx    (idx_q),
      .hit    (hit),
      .slot   (hit_slot)
   );

   assign scan_last = (idx_q == IW'(N_SPR-1));

   // A new line pulse pre-empts the sprite under test in that cycle.
   assign take  = (state_q == ST_SCAN) && !i_line && hit && (cnt_q <  CW'(N_SLOT));
   assign spill = (state_q == ST_SCAN) && !i_line && hit && (cnt_q == CW'(N_SLOT));

   // Pending slot list including the current sprite, so the last scan cycle
   // can hand a complete list straight to the output registers.
   always_comb begin
      cnt_d = cnt_q;
      for (int k = 0; k < N_SLOT; k++)
         pend_d[k] = pend_q[k];
      if (take) begin
         cnt_d = cnt_q + 1'b1;
         for (int k = 0; k < N_SLOT; k++)
            if (cnt_q == CW'(k))
               pend_d[k] = hit_slot;
      end
      for (int k = 0; k < N_SLOT; k++)
         mask_d[k] = (CW'(k) < cnt_d);
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
      if (!i_rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (i_line) state_d = ST_SCAN;
         ST_SCAN:  if (i_line)         state_d = ST_SCAN;
                   else if (scan_last) state_d = ST_ISSUE;
         ST_ISSUE: state_d = i_line ? ST_SCAN : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_busy   = (state_q != ST_IDLE);
      // Slot registers load on the edge into ISSUE, so x/row/id are already
      // valid in the cycle that carries the start pulse.
      load_out = (state_q == ST_SCAN) && !i_line && scan_last;
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idx_q    <= '0;
         line_y_q <= '0;
         cnt_q    <= '0;
         vld_q    <= '0;
         start_q  <= '0;
         ovf_q    <= 1'b0;
         for (int k = 0; k < N_SLOT; k++) begin
            pend_q[k] <= '0;
            out_q[k]  <= '0;
         end
      end else begin
         start_q <= '0;
         if (i_line) begin
            idx_q    <= '0;
            line_y_q <= i_sy;
            cnt_q    <= '0;
            for (int k = 0; k < N_SLOT; k++)
               pend_q[k] <= '0;
         end else if (state_q == ST_SCAN) begin
            idx_q <= idx_q + 1'b1;
            cnt_q <= cnt_d;
            for (int k = 0; k < N_SLOT; k++)
               pend_q[k] <= pend_d[k];
         end
         if (load_out) begin
            vld_q   <= mask_d;
            start_q <= mask_d;
            for (int k = 0; k < N_SLOT; k++)
               out_q[k] <= pend_d[k];
         end
         // A spill in the frame-pulse cycle keeps the flag set.
         if (spill)
            ovf_q <= 1'b1;
         else if (i_frame)
            ovf_q <= 1'b0;
      end
   end

   genvar g;
   generate
      for (g = 0; g < N_SLOT; g++) begin : g_slot
         assign o_slot_x[g*CORDW +: CORDW] = out_q[g].x;
         assign o_slot_row[g*RW +: RW]     = out_q[g].row;
         assign o_slot_id[g*IW +: IW]      = out_q[g].id;
      end
   endgenerate

   assign o_slot_start = start_q;
   assign o_slot_vld   = vld_q;
   assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
`timescale 1ns/1ps
module tb_sprite_line_scheduler;

   localparam int N_SPR  = 8;
   localparam int N_SLOT = 4;
   localparam int CORDW  = 16;
   localparam int SPR_H  = 8;

   logic                         clk;
   logic                         rst_n;
   logic                         line;
   logic                         frame;
   logic signed [CORDW-1:0]      sy;
   logic                         cfg_we;
   logic [2:0]                   cfg_idx;
   logic                         cfg_en;
   logic signed [CORDW-1:0]      cfg_x;
   logic signed [CORDW-1:0]      cfg_y;
   logic [N_SLOT-1:0]            slot_start;
   logic [N_SLOT-1:0]            slot_vld;
   logic [N_SLOT*CORDW-1:0]      slot_x;
   logic [N_SLOT*3-1:0]          slot_row;
   logic [N_SLOT*3-1:0]          slot_id;
   logic                         busy;
   logic                         overflow;

   sprite_line_scheduler #(
      .N_SPR(N_SPR), .N_SLOT(N_SLOT), .CORDW(CORDW), .SPR_H(SPR_H)
   ) dut (
      .i_clk_25     (clk),
      .i_rst_n      (rst_n),
      .i_line       (line),
      .i_frame      (frame),
      .i_sy         (sy),
      .i_cfg_we     (cfg_we),
      .i_cfg_idx    (cfg_idx),
      .i_cfg_en     (cfg_en),
      .i_cfg_x      (cfg_x),
      .i_cfg_y      (cfg_y),
      .o_slot_start (slot_start),
      .o_slot_vld   (slot_vld),
      .o_slot_x     (slot_x),
      .o_slot_row   (slot_row),
      .o_slot_id    (slot_id),
      .o_busy       (busy),
      .o_overflow   (overflow)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct packed {
      logic [31:0]       cyc;
      logic [31:0]       n;
      logic [3:0][15:0]  x;
      logic [3:0][2:0]   row;
      logic [3:0][2:0]   id;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b0;
   logic prev_busy = 1'b0;
   logic [N_SLOT-1:0] prev_start = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: the issue cycle is the last busy cycle before o_busy drops.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en && prev_busy && !busy) begin
         if (q.size() == 0) begin
            chk("unexpected_issue", 64'(cyc - 1), 64'hFFFF_FFFF);
         end else begin
            e = q.pop_front();
            chk("issue_cycle", 64'(cyc - 1), 64'(e.cyc));
            chk("start_mask", 64'(prev_start), 64'((1 << e.n) - 1));
            chk("vld_mask", 64'(slot_vld), 64'((1 << e.n) - 1));
            for (int k = 0; k < N_SLOT; k++) begin
               if (k < int'(e.n)) begin
                  chk($sformatf("slot%0d_x", k),   64'(slot_x[k*16 +: 16]), 64'(e.x[k]));
                  chk($sformatf("slot%0d_row", k), 64'(slot_row[k*3 +: 3]), 64'(e.row[k]));
                  chk($sformatf("slot%0d_id", k),  64'(slot_id[k*3 +: 3]),  64'(e.id[k]));
               end
            end
         end
      end
      prev_busy  = busy;
      prev_start = slot_start;
   end

   task automatic wr(input int idx, input logic en, input int x, input int y, input logic frm);
      @(negedge clk);
      cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_en = en;
      cfg_x = 16'(x); cfg_y = 16'(y); frame = frm;
      @(negedge clk);
      cfg_we = 1'b0; frame = 1'b0;
   endtask

   task automatic pulse_frame();
      @(negedge clk); frame = 1'b1;
      @(negedge clk); frame = 1'b0;
   endtask

   task automatic drive_line(input int y, output int k);
      @(negedge clk);
      line = 1'b1; sy = 16'(y); k = cyc;
      @(negedge clk);
      line = 1'b0;
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 40; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      if (busy) chk("idle_timeout", 64'(busy), 64'd0);
      @(negedge clk);
   endtask

   // Line with a single expected slot, or none when n == 0.
   task automatic line1(input int y, input int n, input int x0, input int r0, input int id0);
      exp_t e;
      int k;
      drive_line(y, k);
      e = '0; e.cyc = 32'(k + N_SPR + 1); e.n = 32'(n);
      e.x[0] = 16'(x0); e.row[0] = 3'(r0); e.id[0] = 3'(id0);
      q.push_back(e);
      wait_idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int k;
      rst_n = 1'b0; line = 1'b0; frame = 1'b0; sy = '0;
      cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_x = '0; cfg_y = '0;
      repeat (3) @(negedge clk);
      chk("rst_start", 64'(slot_start), 64'd0);
      chk("rst_vld", 64'(slot_vld), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_xrowid", 64'({slot_x, slot_row, slot_id}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;

      // empty table
      line1(0, 0, 0, 0, 0);

      // write coinciding with the frame pulse is visible immediately
      wr(0, 1'b1, 16, 16, 1'b1);
      line1(20, 1, 16, 4, 0);

      // five hits, four slots, overflow
      wr(1, 1'b1, 101, 0, 1'b0);
      wr(3, 1'b1, 103, 0, 1'b0);
      wr(5, 1'b1, 105, 0, 1'b0);
      wr(6, 1'b1, 106, 0, 1'b0);
      wr(7, 1'b1, 107, 0, 1'b1);
      drive_line(3, k);
      e = '0; e.cyc = 32'(k + N_SPR + 1); e.n = 4;
      e.x[0] = 16'd101; e.x[1] = 16'd103; e.x[2] = 16'd105; e.x[3] = 16'd106;
      e.row[0] = 3'd3; e.row[1] = 3'd3; e.row[2] = 3'd3; e.row[3] = 3'd3;
      e.id[0] = 3'd1;  e.id[1] = 3'd3;  e.id[2] = 3'd5;  e.id[3] = 3'd6;
      q.push_back(e);
      wait_idle();
      chk("overflow_set", 64'(overflow), 64'd1);
      pulse_frame();
      chk("overflow_clr", 64'(overflow), 64'd0);

      // shadow write without frame is not scanned
      wr(2, 1'b1, 50, 100, 1'b0);
      line1(100, 0, 0, 0, 0);
      pulse_frame();
      line1(100, 1, 50, 0, 2);

      // coordinate boundaries
      for (int i = 0; i < N_SPR; i++) wr(i, 1'b0, 0, 0, 1'b0);
      wr(4, 1'b1, -8, -4, 1'b1);
      line1(3, 1, -8, 7, 4);
      line1(4, 0, 0, 0, 0);
      wr(4, 1'b1, 20, 32760, 1'b1);
      line1(-32768, 0, 0, 0, 0);
      line1(32767, 1, 20, 7, 4);

      // restart during scan: only the second line is issued
      wr(0, 1'b1, 5, 8, 1'b1);
      drive_line(10, k);
      repeat (2) @(negedge clk);
      drive_line(11, k);
      e = '0; e.cyc = 32'(k + N_SPR + 1); e.n = 1;
      e.x[0] = 16'd5; e.row[0] = 3'd3; e.id[0] = 3'd0;
      q.push_back(e);
      wait_idle();

      // reset during scan
      mon_en = 1'b0;
      drive_line(10, k);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_vld", 64'(slot_vld), 64'd0);
      chk("midrst_start", 64'(slot_start), 64'd0);
      repeat (12) @(negedge clk);
      chk("midrst_start_late", 64'(slot_start), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      mon_en = 1'b1;
      // table was cleared by the reset
      line1(10, 0, 0, 0, 0);

      for (int i = 0; i < 50; i++) begin
         if (q.size() == 0) break;
         @(negedge clk);
      end
      chk("queue_drained", 64'(q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
